// File: rtl/pipe_pkg.sv
// Shared pipeline types: the Execute->Memory payload and its field widths.
// Width macros may be supplied by the codebase's defines.sv; these are fallbacks.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef INSTR_TYPE_SZ
`define INSTR_TYPE_SZ 4
`endif
`ifndef ROB_ENTRY_WIDTH
`define ROB_ENTRY_WIDTH 3
`endif

package pipe_pkg;

    localparam int unsigned WordSize      = `WORD_SIZE;
    localparam int unsigned InstrTypeSz   = `INSTR_TYPE_SZ;
    localparam int unsigned RobEntryWidth = `ROB_ENTRY_WIDTH;

    typedef struct packed {
        logic [InstrTypeSz-1:0]   instruction_type;
        logic [WordSize-1:0]      pc;
        logic [2:0]               funct3;
        logic [WordSize-1:0]      alu_result;
        logic [WordSize-1:0]      s2;
        logic [RobEntryWidth-1:0] rob_id;
    } em_payload_t;

endpackage

// File: rtl/exec_mem_queue_if.sv
// Producer/consumer handshake bundle for the E->M queue.
// master = ALU/AGU side driving in_* and the D-cache side's out_ready; slave = the queue.
interface exec_mem_queue_if;
    import pipe_pkg::*;

    logic                     in_valid;
    logic                     in_ready;
    logic [InstrTypeSz-1:0]   in_instruction_type;
    logic [WordSize-1:0]      in_pc;
    logic [2:0]               in_funct3;
    logic [WordSize-1:0]      in_alu_result;
    logic [WordSize-1:0]      in_s2;
    logic [RobEntryWidth-1:0] in_rob_id;

    logic                     out_valid;
    logic                     out_ready;
    logic [InstrTypeSz-1:0]   out_instruction_type;
    logic [WordSize-1:0]      out_pc;
    logic [2:0]               out_funct3;
    logic [WordSize-1:0]      out_alu_result;
    logic [WordSize-1:0]      out_s2;
    logic [RobEntryWidth-1:0] out_rob_id;

    modport master (
        output in_valid, in_instruction_type, in_pc, in_funct3, in_alu_result, in_s2, in_rob_id,
        output out_ready,
        input  in_ready,
        input  out_valid, out_instruction_type, out_pc, out_funct3, out_alu_result, out_s2,
        input  out_rob_id
    );

    modport slave (
        input  in_valid, in_instruction_type, in_pc, in_funct3, in_alu_result, in_s2, in_rob_id,
        input  out_ready,
        output in_ready,
        output out_valid, out_instruction_type, out_pc, out_funct3, out_alu_result, out_s2,
        output out_rob_id
    );

endinterface

// File: rtl/rob_age_younger.sv
// Flags a ROB tag as squashed when it is the kill tag or younger, ages taken
// relative to the ROB head so tag wrap-around is handled.
module rob_age_younger #(
    parameter int unsigned Width = 3
) (
    input  logic [Width-1:0] tag_i,
    input  logic [Width-1:0] kill_tag_i,
    input  logic [Width-1:0] head_i,
    output logic             squash_o
);

    logic [Width-1:0] tag_age;
    logic [Width-1:0] kill_age;

    // Modular subtraction gives distance from the head.
    always_comb begin
        tag_age  = tag_i - head_i;
        kill_age = kill_tag_i - head_i;
        squash_o = (tag_age >= kill_age);
    end

endmodule

// File: rtl/exec_mem_queue.sv
// Elastic, squashable Execute->Memory queue: DEPTH-slot circular buffer with
// valid/ready on both sides, full flush and ROB-age based selective kill.
module exec_mem_queue
    import pipe_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    exec_mem_queue_if.slave          q_if,
    input  logic                     flush,
    input  logic                     kill_valid,
    input  logic [RobEntryWidth-1:0] kill_rob_id,
    input  logic [RobEntryWidth-1:0] rob_head_id,
    output logic [CNT_W-1:0]         count
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    typedef logic [PtrW-1:0] ptr_t;

    em_payload_t       mem_q [DEPTH];
    ptr_t              head_q, head_d;
    ptr_t              tail_q, tail_d;
    ptr_t              wr_ptr;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              pop, push, wr_en;
    logic [DEPTH-1:0]  slot_sq;
    logic              in_sq;
    em_payload_t       in_pl;
    em_payload_t       head_pl;

    // Pointer advance with explicit wrap so DEPTH need not be a power of two.
    function automatic ptr_t wrap_add(ptr_t base, int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= DEPTH) s = s - DEPTH;
        return ptr_t'(s);
    endfunction

    assign in_pl = '{
        instruction_type: q_if.in_instruction_type,
        pc:               q_if.in_pc,
        funct3:           q_if.in_funct3,
        alu_result:       q_if.in_alu_result,
        s2:               q_if.in_s2,
        rob_id:           q_if.in_rob_id
    };

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot_age
        rob_age_younger #(.Width(RobEntryWidth)) u_age (
            .tag_i      (mem_q[g].rob_id),
            .kill_tag_i (kill_rob_id),
            .head_i     (rob_head_id),
            .squash_o   (slot_sq[g])
        );
    end

    rob_age_younger #(.Width(RobEntryWidth)) u_age_in (
        .tag_i      (q_if.in_rob_id),
        .kill_tag_i (kill_rob_id),
        .head_i     (rob_head_id),
        .squash_o   (in_sq)
    );

    // Next state: pop first, then trim the squashed suffix, then append the survivor.
    always_comb begin
        int unsigned keep;
        logic        found;
        ptr_t        slot;
        pop   = (count_q != '0) && q_if.out_ready;
        push  = (count_q != CNT_W'(DEPTH)) && q_if.in_valid;
        found = 1'b0;
        keep  = 32'(count_q) - 32'(pop);
        slot  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            slot = wrap_add(head_q, i);
            // A popped head counts as delivered and is exempt from the kill.
            if (kill_valid && !found && (i < 32'(count_q)) && !(pop && i == 0) && slot_sq[slot]) begin
                found = 1'b1;
                keep  = i - 32'(pop);
            end
        end
        wr_ptr  = found ? wrap_add(head_q, 32'(pop) + keep) : tail_q;
        wr_en   = push && !(kill_valid && in_sq);
        head_d  = pop ? wrap_add(head_q, 1) : head_q;
        tail_d  = wr_en ? wrap_add(wr_ptr, 1) : wr_ptr;
        count_d = CNT_W'(keep + 32'(wr_en));
    end

    // State update: reset clears storage too; flush only empties the pointers.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (wr_en) mem_q[wr_ptr] <= in_pl;
        end
    end

    assign head_pl                   = mem_q[head_q];
    assign q_if.in_ready             = (count_q != CNT_W'(DEPTH));
    assign q_if.out_valid            = (count_q != '0);
    assign q_if.out_instruction_type = head_pl.instruction_type;
    assign q_if.out_pc               = head_pl.pc;
    assign q_if.out_funct3           = head_pl.funct3;
    assign q_if.out_alu_result       = head_pl.alu_result;
    assign q_if.out_s2               = head_pl.s2;
    assign q_if.out_rob_id           = head_pl.rob_id;
    assign count                     = count_q;

endmodule

// File: tb/tb_exec_mem_queue.sv
// Randomised + directed bench for exec_mem_queue with a queue-based reference model.
module tb_exec_mem_queue;
    import pipe_pkg::*;

    localparam int unsigned DEPTH  = 3;
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int          TagMod = 1 << RobEntryWidth;

    logic                     clk;
    logic                     reset;
    logic                     flush;
    logic                     kill_valid;
    logic [RobEntryWidth-1:0] kill_rob_id;
    logic [RobEntryWidth-1:0] rob_head_id;
    logic [CNT_W-1:0]         count;

    exec_mem_queue_if q_if ();

    exec_mem_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .q_if        (q_if),
        .flush       (flush),
        .kill_valid  (kill_valid),
        .kill_rob_id (kill_rob_id),
        .rob_head_id (rob_head_id),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: contents of the queue in program order, plus deliveries still to be seen.
    em_payload_t              mq[$];
    em_payload_t              exp_out[$];
    em_payload_t              exp_head;
    int                       exp_count;
    logic                     exp_hold;
    logic                     exp_zero;
    logic                     chk_en;
    logic                     armed;
    logic                     last_rst;
    logic [RobEntryWidth-1:0] next_tag;
    int                       checks;
    int                       errors;

    function automatic int age(logic [RobEntryWidth-1:0] x, logic [RobEntryWidth-1:0] h);
        return (int'(x) - int'(h) + TagMod) % TagMod;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model absorbs the effect of the coming edge.
    task automatic step(input logic rst, input logic fl, input logic iv, input logic [31:0] pc,
                        input logic ordy, input logic kv, input int kage);
        em_payload_t              pl;
        logic [RobEntryWidth-1:0] head_tag;
        logic                     acc;
        @(posedge clk);
        #2;
        chk_en    = armed;
        armed     = 1'b1;
        exp_zero  = last_rst;
        last_rst  = rst;
        exp_hold  = rst || fl;
        exp_count = mq.size();
        if (mq.size() != 0) exp_head = mq[0];
        head_tag = (mq.size() != 0) ? mq[0].rob_id : next_tag;

        pl.instruction_type = InstrTypeSz'($urandom);
        pl.pc               = pc;
        pl.funct3           = 3'($urandom);
        pl.alu_result       = WordSize'($urandom);
        pl.s2               = WordSize'($urandom);
        pl.rob_id           = next_tag;

        reset                    = rst;
        flush                    = fl;
        kill_valid               = kv;
        rob_head_id              = head_tag;
        kill_rob_id              = head_tag + RobEntryWidth'(kage);
        q_if.in_valid            = iv;
        q_if.out_ready           = ordy;
        q_if.in_instruction_type = pl.instruction_type;
        q_if.in_pc               = pl.pc;
        q_if.in_funct3           = pl.funct3;
        q_if.in_alu_result       = pl.alu_result;
        q_if.in_s2               = pl.s2;
        q_if.in_rob_id           = pl.rob_id;

        acc = iv && (mq.size() != DEPTH);
        if (rst || fl) begin
            mq.delete();
        end else begin
            if (ordy && mq.size() != 0) exp_out.push_back(mq.pop_front());
            if (kv)
                while (mq.size() != 0 && age(mq[$].rob_id, head_tag) >= kage) void'(mq.pop_back());
            if (acc && !(kv && age(pl.rob_id, head_tag) >= kage)) mq.push_back(pl);
            if (acc) next_tag = next_tag + 1'b1;
            if (kv) next_tag = kill_rob_id;
        end
    endtask

    task automatic push(input logic [31:0] pc);
        step(1'b0, 1'b0, 1'b1, pc, 1'b0, 1'b0, 0);
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 1'b0, 1'b0, 32'h0, ordy, 1'b0, 0);
    endtask

    // Monitor: compares DUT state mid-cycle against what the model expects.
    initial begin
        em_payload_t got;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                got = '{instruction_type: q_if.out_instruction_type, pc: q_if.out_pc,
                        funct3: q_if.out_funct3, alu_result: q_if.out_alu_result,
                        s2: q_if.out_s2, rob_id: q_if.out_rob_id};
                check("count", 128'(count), 128'(exp_count));
                check("out_valid", 128'(q_if.out_valid), 128'(exp_count != 0));
                check("in_ready", 128'(q_if.in_ready), 128'(exp_count != DEPTH));
                if (exp_count != 0) check("head", 128'(got), 128'(exp_head));
                if (exp_zero) check("reset_fields", 128'(got), 128'(0));
                if (q_if.out_valid && q_if.out_ready && !exp_hold) begin
                    if (exp_out.size() == 0) check("unexpected_pop", 128'(1), 128'(0));
                    else check("delivered", 128'(got), 128'(exp_out.pop_front()));
                end
            end
        end
    end

    initial begin
        int sz;
        checks   = 0;
        errors   = 0;
        chk_en   = 1'b0;
        armed    = 1'b0;
        last_rst = 1'b0;
        exp_hold = 1'b0;
        exp_zero = 1'b0;
        next_tag = '0;
        reset = 1'b1; flush = 1'b0; kill_valid = 1'b0; kill_rob_id = '0; rob_head_id = '0;
        q_if.in_valid = 1'b0; q_if.out_ready = 1'b0;
        q_if.in_instruction_type = '0; q_if.in_pc = '0; q_if.in_funct3 = '0;
        q_if.in_alu_result = '0; q_if.in_s2 = '0; q_if.in_rob_id = '0;

        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 0);
        // Single push, then fill, overflow attempt, in-order drain.
        push(32'h100);
        push(32'h104);
        push(32'h108);
        push(32'h10C);
        idle(1'b1); idle(1'b1); idle(1'b1); idle(1'b0);
        // Kill across tag wrap: tags 6,7,0, kill 0 leaves 6,7.
        next_tag = 3'(6);
        push(32'h200); push(32'h204); push(32'h208);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 2);
        idle(1'b0);
        idle(1'b1); idle(1'b1); idle(1'b0);
        // Pop + kill + push on one edge.
        next_tag = 3'(2);
        push(32'h300); push(32'h304);
        step(1'b0, 1'b0, 1'b1, 32'h308, 1'b1, 1'b1, 1);
        idle(1'b0);
        // Flush while full with an offered payload.
        push(32'h400); push(32'h404); push(32'h408);
        step(1'b0, 1'b1, 1'b1, 32'h40C, 1'b0, 1'b0, 0);
        idle(1'b0);
        // Reset mid-handshake with two entries queued.
        push(32'h500); push(32'h504);
        step(1'b1, 1'b0, 1'b1, 32'h508, 1'b1, 1'b0, 0);
        idle(1'b0);

        for (int n = 0; n < 3000; n++) begin
            sz = mq.size();
            step(($urandom_range(199, 0) == 0), ($urandom_range(49, 0) == 0),
                 ($urandom_range(9, 0) < 7), $urandom, ($urandom_range(9, 0) < 6),
                 ($urandom_range(7, 0) == 0), int'($urandom_range(sz, 0)));
        end
        for (int n = 0; n < DEPTH + 2; n++) idle(1'b1);
        idle(1'b0);
        @(negedge clk);
        #1;
        check("drained", 128'(exp_out.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
